intpol2_iq_sink: RTL

Synthesizable drain for the IQ interpolator output path. Reads a programmed number of sample pairs from the I and Q output FIFOs and writes each pair to a sample memory at consecutive addresses. Pulses `done_o` when the last pair has been written. It is the reader-side counterpart of the interpolator's FIFO write port. It replaces the behavioural sink in system-level integration.

---
 rtl/intpol2_pkg.sv | 13 +
 rtl/intpol2_iq_sink.sv | 97 +++++++++
 2 files changed

// File: rtl/intpol2_pkg.sv
// rtl/intpol2_pkg.sv - shared types and default widths for the IQ interpolator path
package intpol2_pkg;

  localparam int IQ_DATA_WIDTH = 12;
  localparam int IQ_ADDR_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sink_state_e;

endpackage

// File: rtl/intpol2_iq_sink.sv
// rtl/intpol2_iq_sink.sv - drains len IQ pairs from the output FIFOs into sample memory
module intpol2_iq_sink
  import intpol2_pkg::*;
#(
  parameter int DATA_WIDTH = IQ_DATA_WIDTH,
  parameter int ADDR_WIDTH = IQ_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] len_i,
  input  logic                  Empty_i,
  input  logic [DATA_WIDTH-1:0] data_I_i,
  input  logic [DATA_WIDTH-1:0] data_Q_i,
  output logic                  Read_Enable_o,
  output logic                  Write_Enable_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] data_I_o,
  output logic [DATA_WIDTH-1:0] data_Q_o,
  output logic                  busy_o,
  output logic                  done_o
);

  sink_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                  we_q, we_d;
  logic                  rd_en;
  logic                  last_wr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      we_q     <= we_d;
    end
  end

  // len_q is never zero in RUN, so len_q - 1 cannot underflow there.
  assign last_wr = we_q && (wr_cnt_q == len_q - ADDR_WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    we_d     = 1'b0;
    rd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d    = len_i;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = (len_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        rd_en = !Empty_i && (rd_cnt_q != len_q);
        we_d  = rd_en;
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
        end
        if (we_q) begin
          wr_cnt_d = wr_cnt_q + ADDR_WIDTH'(1);
        end
        if (last_wr) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Read_Enable_o  = rd_en;
  assign Write_Enable_o = we_q;
  assign addr_o         = wr_cnt_q;
  assign data_I_o       = data_I_i;
  assign data_Q_o       = data_Q_i;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);

endmodule
